adc_ext_ctrl_receiver: RTL and testbench
========================================

# adc_ext_ctrl_receiver

Serial-register receiver for the ADC extended-control interface. It is the listening end of the 3-wire write link (`sclk`, `sdata`, `select`) driven by the ADC extended-control master. It decodes 32-bit write frames into a 16 x 16-bit register file and reports protocol errors. It serves as a bench/ADC stand-in model and as the slave side when a second FPGA hosts the register map.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `sclk`/`sdata`/`select` (min 2).
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `sclk` input 1: serial clock from master, asynchronous to `clk`; data sampled on its rising edge.
- `sdata` input 1: serial data, MSB first.
- `select` input 1: active-low frame enable.
- `rd_addr` input 4: register file read address.
- `rd_data` output 16: combinational read of register `rd_addr`.
- `wr_strobe` output 1: one-cycle pulse on each committed write.
- `wr_addr` output 4: address of last committed write.
- `wr_data` output 16: data of last committed write.
- `frame_err` output 1: one-cycle pulse on a rejected frame.
- `des_enabled` output 1: mirror of register 4'hA bit 15.
- `frame_count` output 8: count of committed writes, wraps 255->0.

## Operation
- Frame: 32 bits, MSB first. Bits [31:20] are header 12'h001, bits [19:16] are address, bits [15:0] are data.
- Each input passes through `SYNC_STAGES` flops. Edges are detected by comparing the last sync stage with one extra delayed copy.
- States:
  - WAIT_IDLE (entered at reset): stay until synchronized `select` = 1, then go to IDLE. A frame in progress at reset release is ignored.
  - IDLE: on synchronized `select` falling, clear the shift register and the 6-bit bit counter, then go to SHIFT.
  - SHIFT: on each synchronized `sclk` rising edge, shift in `sdata` and increment the counter. The counter saturates at 33. On `select` rising, go to COMMIT.
  - COMMIT (one cycle): if counter == 32 and header == 12'h001, perform the commit actions below. Otherwise pulse `frame_err` and leave the register file untouched. Return to IDLE.
- Commit actions: write `reg[addr] <= data`, pulse `wr_strobe`, update `wr_addr`/`wr_data`, increment `frame_count`.
- `sclk` edges seen while `select` = 1 are ignored.
- Frames with more than 32 clocks are errors (counter value 33). They are not truncated.
- Register file: 16 x 16 flops, all reset to 16'h0000. Writes to any address are accepted. `des_enabled` = `reg[4'hA][15]`.
- Reset values: `wr_strobe` = 0, `frame_err` = 0, `wr_addr` = 0, `wr_data` = 0, `frame_count` = 0, `des_enabled` = 0, `rd_data` = 0. State is WAIT_IDLE.
- Reset mid-frame: the frame is discarded, no strobe or error is generated, and the block waits for `select` high.

## Timing
- The master must hold `sclk` high ≥ 2 `clk` periods and low ≥ 2 `clk` periods. `sdata` must be stable ≥ 2 `clk` periods before and after each `sclk` rising edge. `select` must be high ≥ 3 `clk` periods between frames.
- With `SYNC_STAGES` = 2, `select` is first sampled high at `clk` edge k. The transition to COMMIT happens at edge k+2. `wr_strobe`/`frame_err` are high for the single cycle following edge k+3. `reg`, `wr_addr`, `wr_data`, `frame_count` and `des_enabled` update at that same edge k+3.
- `rd_data` reflects a write in the same cycle that `wr_strobe` is high.
- The commit latency scales by +1 `clk` per extra synchronizer stage.
- `wr_strobe` and `frame_err` are never high together.

## Test plan
- Reset, then one frame 32'h001A_8000 (`clk` 10 ns, `sclk` 100 ns) -> one `wr_strobe`, `wr_addr` = 4'hA, `wr_data` = 16'h8000, `des_enabled` = 1, `frame_count` = 1, `rd_data` at addr A = 16'h8000.
- Follow with 32'h001A_0000 -> `des_enabled` = 0, `frame_count` = 2. Then 32'h0013_1234 -> `rd_data` at addr 3 = 16'h1234, addr A still 16'h0000.
- Bad header 32'h002F_FFFF, plus a 31-bit frame, plus a 33-bit frame -> three `frame_err` pulses, no `wr_strobe`, register file and `frame_count` unchanged.
- `sclk` toggling 10 times with `select` high, then a valid frame 32'h0015_00FF -> only the framed write lands. `reg[5]` = 16'h00FF.
- Assert `rst` after bit 20 of a valid frame, release with `select` still low, finish the frame -> no strobe, no error. The next full frame 32'h0011_0001 commits normally.
- 256 valid frames -> `frame_count` wraps to 0. Measure latency from `select` rising to `wr_strobe` = 4 `clk` edges ±1 for asynchronous phase.

Source files
------------

// File: rtl/adc_ext_ctrl_receiver.sv
// adc_ext_ctrl_receiver
// Listening end of the 3-wire ADC extended-control write link. Frames are
// 32 bits, MSB first: 12-bit header 12'h001, 4-bit address, 16-bit data.
// Good frames land in a 16 x 16 register file; malformed frames pulse
// frame_err_o and leave the register file alone.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_IDLE | after reset, ignore any frame in flight until select is high
// IDLE      | link quiet, waiting for select to fall
// SHIFT     | collecting bits on sclk rising edges
// COMMIT    | one cycle: validate length/header, write or flag error

module adc_ext_ctrl_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sclk_i,
    input  logic        sdata_i,
    input  logic        select_i,
    input  logic [3:0]  rd_addr_i,
    output logic [15:0] rd_data_o,
    output logic        wr_strobe_o,
    output logic [3:0]  wr_addr_o,
    output logic [15:0] wr_data_o,
    output logic        frame_err_o,
    output logic        des_enabled_o,
    output logic [7:0]  frame_count_o
);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        COMMIT    = 2'd3
    } state_t;

    localparam logic [11:0] HEADER  = 12'h001;
    localparam logic [5:0]  CNT_MAX = 6'd33;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] sdata_sync_q;
    logic [SYNC_STAGES-1:0] sel_sync_q;
    logic                   sclk_del_q;
    logic                   sel_del_q;

    logic sclk_s, sdata_s, sel_s;
    logic sclk_rise_d, sel_rise_d, sel_fall_d;
    logic [5:0] cnt_inc_d;

    state_t       state_q;
    logic [31:0]  shift_q;
    logic [5:0]   cnt_q;
    logic [15:0]  regs_q [16];
    logic         wr_strobe_q;
    logic         frame_err_q;
    logic [3:0]   wr_addr_q;
    logic [15:0]  wr_data_q;
    logic [7:0]   frame_count_q;

    // Synchronizers plus one extra delayed copy for edge detection. select
    // resets low so a frame in flight at reset release is not mistaken for idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_sync_q  <= '0;
            sdata_sync_q <= '0;
            sel_sync_q   <= '0;
            sclk_del_q   <= 1'b0;
            sel_del_q    <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata_i};
            sel_sync_q   <= {sel_sync_q[SYNC_STAGES-2:0], select_i};
            sclk_del_q   <= sclk_sync_q[SYNC_STAGES-1];
            sel_del_q    <= sel_sync_q[SYNC_STAGES-1];
        end
    end

    // Edge detection on the synchronized link signals.
    always_comb begin
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        sdata_s     = sdata_sync_q[SYNC_STAGES-1];
        sel_s       = sel_sync_q[SYNC_STAGES-1];
        sclk_rise_d = sclk_s & ~sclk_del_q;
        sel_rise_d  = sel_s & ~sel_del_q;
        sel_fall_d  = ~sel_s & sel_del_q;
        cnt_inc_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 6'd1;
    end

    // Frame FSM with register file and registered status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= WAIT_IDLE;
            shift_q       <= '0;
            cnt_q         <= '0;
            wr_strobe_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_count_q <= '0;
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                WAIT_IDLE: begin
                    if (sel_s) state_q <= IDLE;
                end
                IDLE: begin
                    if (sel_fall_d) begin
                        shift_q <= '0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sel_rise_d) begin
                        state_q <= COMMIT;
                    end else if (sclk_rise_d) begin
                        shift_q <= {shift_q[30:0], sdata_s};
                        cnt_q   <= cnt_inc_d;
                    end
                end
                COMMIT: begin
                    // Overlong frames saturate at 33 and therefore fail here.
                    if (cnt_q == 6'd32 && shift_q[31:20] == HEADER) begin
                        regs_q[shift_q[19:16]] <= shift_q[15:0];
                        wr_strobe_q            <= 1'b1;
                        wr_addr_q              <= shift_q[19:16];
                        wr_data_q              <= shift_q[15:0];
                        frame_count_q          <= frame_count_q + 8'd1;
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= WAIT_IDLE;
            endcase
        end
    end

    // Output mapping; reads are combinational so a write is visible with its strobe.
    always_comb begin
        rd_data_o     = regs_q[rd_addr_i];
        des_enabled_o = regs_q[4'hA][15];
        wr_strobe_o   = wr_strobe_q;
        frame_err_o   = frame_err_q;
        wr_addr_o     = wr_addr_q;
        wr_data_o     = wr_data_q;
        frame_count_o = frame_count_q;
    end

endmodule

// File: tb/tb_adc_ext_ctrl_receiver.sv
// Directed bench for adc_ext_ctrl_receiver: drives the 3-wire link and
// compares outputs against hand-computed values.

module tb_adc_ext_ctrl_receiver;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        sclk_i;
    logic        sdata_i;
    logic        select_i;
    logic [3:0]  rd_addr_i;
    logic [15:0] rd_data_o;
    logic        wr_strobe_o;
    logic [3:0]  wr_addr_o;
    logic [15:0] wr_data_o;
    logic        frame_err_o;
    logic        des_enabled_o;
    logic [7:0]  frame_count_o;

    int n_checks = 0;
    int n_errors = 0;
    int n_strobe = 0;
    int n_err    = 0;
    int n_both   = 0;
    int last_lat = 0;

    adc_ext_ctrl_receiver #(.SYNC_STAGES(2)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .sclk_i        (sclk_i),
        .sdata_i       (sdata_i),
        .select_i      (select_i),
        .rd_addr_i     (rd_addr_i),
        .rd_data_o     (rd_data_o),
        .wr_strobe_o   (wr_strobe_o),
        .wr_addr_o     (wr_addr_o),
        .wr_data_o     (wr_data_o),
        .frame_err_o   (frame_err_o),
        .des_enabled_o (des_enabled_o),
        .frame_count_o (frame_count_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (wr_strobe_o) n_strobe++;
            if (frame_err_o) n_err++;
            if (wr_strobe_o && frame_err_o) n_both++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] d);
        rd_addr_i = a;
        #1;
        d = rd_data_o;
    endtask

    task automatic shift_bits(input logic [63:0] v, input int hi, input int lo, input int hp);
        for (int i = hi; i >= lo; i--) begin
            sdata_i = v[i];
            #hp sclk_i = 1'b1;
            #hp sclk_i = 1'b0;
        end
    endtask

    // Sends n bits of v, then waits for the resulting strobe or error pulse
    // and records the number of clk edges from select rising to it.
    task automatic send_bits(input logic [63:0] v, input int n, input int hp);
        int cnt;
        select_i = 1'b0;
        #hp;
        shift_bits(v, n - 1, 0, hp);
        #hp select_i = 1'b1;
        cnt = 0;
        last_lat = 99;
        while (cnt < 20) begin
            @(posedge clk_i);
            cnt++;
            @(negedge clk_i);
            if (wr_strobe_o || frame_err_o) begin
                last_lat = cnt;
                break;
            end
        end
        if (last_lat == 99) chk("frame_done_timeout", 32'd0, 32'd1);
        #100;
    endtask

    logic [15:0] d;
    logic [63:0] v;

    initial begin
        rst_i = 1'b1; sclk_i = 1'b0; sdata_i = 1'b0; select_i = 1'b1; rd_addr_i = 4'hA;
        #32 rst_i = 1'b0;
        #50;
        chk("rst_strobe", {31'd0, wr_strobe_o}, 32'd0);
        chk("rst_err", {31'd0, frame_err_o}, 32'd0);
        chk("rst_wr_addr", {28'd0, wr_addr_o}, 32'd0);
        chk("rst_wr_data", {16'd0, wr_data_o}, 32'd0);
        chk("rst_fcount", {24'd0, frame_count_o}, 32'd0);
        chk("rst_des", {31'd0, des_enabled_o}, 32'd0);
        rd(4'hA, d); chk("rst_rd_A", {16'd0, d}, 32'd0);

        send_bits(64'h001A_8000, 32, 50);
        chk("f1_latency_ok", {31'd0, (last_lat >= 3 && last_lat <= 5)}, 32'd1);
        chk("f1_strobes", n_strobe, 1);
        chk("f1_wr_addr", {28'd0, wr_addr_o}, 32'hA);
        chk("f1_wr_data", {16'd0, wr_data_o}, 32'h8000);
        chk("f1_des", {31'd0, des_enabled_o}, 32'd1);
        chk("f1_fcount", {24'd0, frame_count_o}, 32'd1);
        rd(4'hA, d); chk("f1_rd_A", {16'd0, d}, 32'h8000);

        send_bits(64'h001A_0000, 32, 50);
        chk("f2_des", {31'd0, des_enabled_o}, 32'd0);
        chk("f2_fcount", {24'd0, frame_count_o}, 32'd2);
        send_bits(64'h0013_1234, 32, 50);
        rd(4'h3, d); chk("f3_rd_3", {16'd0, d}, 32'h1234);
        rd(4'hA, d); chk("f3_rd_A", {16'd0, d}, 32'h0000);
        chk("f3_wr_addr", {28'd0, wr_addr_o}, 32'h3);

        send_bits(64'h002F_FFFF, 32, 50);
        v = 64'h0014_BEEF >> 1;
        send_bits(v, 31, 50);
        v = {31'd0, 32'h0014_BEEF, 1'b1};
        send_bits(v, 33, 50);
        chk("bad_errs", n_err, 3);
        chk("bad_strobes", n_strobe, 3);
        chk("bad_fcount", {24'd0, frame_count_o}, 32'd3);
        chk("bad_wr_data", {16'd0, wr_data_o}, 32'h1234);
        rd(4'h4, d); chk("bad_rd_4", {16'd0, d}, 32'h0000);
        rd(4'hF, d); chk("bad_rd_F", {16'd0, d}, 32'h0000);
        rd(4'h3, d); chk("bad_rd_3", {16'd0, d}, 32'h1234);

        sdata_i = 1'b1;
        shift_bits(64'h3FF, 9, 0, 50);
        #100;
        chk("noise_strobes", n_strobe, 3);
        chk("noise_errs", n_err, 3);
        send_bits(64'h0015_00FF, 32, 50);
        rd(4'h5, d); chk("noise_rd_5", {16'd0, d}, 32'h00FF);
        chk("noise_fcount", {24'd0, frame_count_o}, 32'd4);

        select_i = 1'b0;
        #50;
        shift_bits(64'h0017_7777, 31, 12, 50);
        rst_i = 1'b1;
        #30 rst_i = 1'b0;
        shift_bits(64'h0017_7777, 11, 0, 50);
        #50 select_i = 1'b1;
        #300;
        chk("mid_rst_strobes", n_strobe, 4);
        chk("mid_rst_errs", n_err, 3);
        chk("mid_rst_fcount", {24'd0, frame_count_o}, 32'd0);
        rd(4'h7, d); chk("mid_rst_rd_7", {16'd0, d}, 32'h0000);
        send_bits(64'h0011_0001, 32, 50);
        chk("post_rst_strobes", n_strobe, 5);
        chk("post_rst_fcount", {24'd0, frame_count_o}, 32'd1);
        rd(4'h1, d); chk("post_rst_rd_1", {16'd0, d}, 32'h0001);

        for (int i = 0; i < 254; i++) begin
            v = {32'd0, 12'h001, i[3:0], i[15:0]};
            send_bits(v, 32, 30);
        end
        chk("wrap_fcount_255", {24'd0, frame_count_o}, 32'd255);
        send_bits(64'h001C_ABCD, 32, 30);
        chk("wrap_latency_ok", {31'd0, (last_lat >= 3 && last_lat <= 5)}, 32'd1);
        chk("wrap_fcount_0", {24'd0, frame_count_o}, 32'd0);
        chk("wrap_strobes", n_strobe, 260);
        chk("wrap_errs", n_err, 3);
        rd(4'hC, d); chk("wrap_rd_C", {16'd0, d}, 32'hABCD);
        chk("strobe_err_overlap", n_both, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
